// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
//   OP_ADD / OP_SUB : encodings of the in_sub mode bit
//   clog2           : ceiling log2 helper for width calculations
//   params_ok       : elaboration-time legality check of WIDTH/BLOCK/STAGES
// -----------------------------------------------------------------------------
package adder_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      for (int i = 0; i < 32; i++) begin
         if (v > 0) begin
            result++;
            v = v >> 1;
         end
      end
      return result;
   endfunction

   // WIDTH must split into whole groups, and the groups into whole stages.
   function automatic bit params_ok(input int width, input int block, input int stages);
      int groups;
      if (block < 1 || width < block || (width % block) != 0) return 1'b0;
      groups = width / block;
      return (stages >= 1) && (stages <= groups) && ((groups % stages) == 0);
   endfunction

endpackage

// File: rtl/cla_group.sv
// -----------------------------------------------------------------------------
// cla_group
// Combinational BLOCK-bit lookahead group.
//   i_x, i_y : group operand slices (y already conditioned for subtract)
//   i_cin    : carry into the group's LSB
//   o_sum    : group sum slice
//   o_g      : group generate (carry out when i_cin = 0)
//   o_p      : group propagate (carry out follows i_cin)
// -----------------------------------------------------------------------------
module cla_group #(
   parameter int BLOCK = 8
) (
   input  logic [BLOCK-1:0] i_x,
   input  logic [BLOCK-1:0] i_y,
   input  logic             i_cin,
   output logic [BLOCK-1:0] o_sum,
   output logic             o_g,
   output logic             o_p
);

   logic [BLOCK-1:0] w_gen;
   logic [BLOCK-1:0] w_prop;

   assign w_gen  = i_x & i_y;
   assign w_prop = i_x ^ i_y;
   assign o_p    = &w_prop;

   always_comb begin
      logic carry;
      logic grp_g;
      o_sum = '0;
      carry = i_cin;
      grp_g = 1'b0;
      // NOTE: blocking assignments are correct here; carry and grp_g are
      // combinational temporaries updated bit by bit within one evaluation.
      for (int i = 0; i < BLOCK; i++) begin
         o_sum[i] = w_prop[i] ^ carry;
         carry    = w_gen[i] | (w_prop[i] & carry);
         grp_g    = w_gen[i] | (w_prop[i] & grp_g);
      end
      o_g = grp_g;
   end

endmodule

// File: rtl/pipe_cla_adder.sv
// -----------------------------------------------------------------------------
// pipe_cla_adder
// Pipelined, parametrised carry-lookahead adder/subtractor with a global
// valid/ready advance. Stage k resolves groups k*GPS .. k*GPS+GPS-1 with
// two-level lookahead and hands its partial sum, the unconsumed operand bits
// and its carry-out to stage k+1.
//   clock, reset_n            : rising-edge clock, async active-low reset
//   in_valid/in_ready         : operand handshake (in_ready = advance)
//   in_x, in_y, in_cin, in_sub: operands; sub computes x + ~y + 1
//   out_valid/out_ready       : result handshake
//   out_sum, out_cout         : result mod 2^WIDTH, carry out of MSB
//   out_ovf, out_zero         : signed overflow, zero (only while valid)
// -----------------------------------------------------------------------------
module pipe_cla_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int BLOCK  = 8,
   parameter int STAGES = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_x,
   input  logic [WIDTH-1:0] in_y,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero
);

   localparam int GROUPS = WIDTH / BLOCK;
   localparam int GPS    = GROUPS / STAGES;
   localparam int SB     = GPS * BLOCK;      // bits resolved per stage
   localparam int LAST   = STAGES - 1;

   if (!params_ok(WIDTH, BLOCK, STAGES)) begin : g_param_err
      $error("pipe_cla_adder: illegal WIDTH/BLOCK/STAGES combination");
   end

   // Carry into each group of a stage as a flat sum of products, so no group
   // waits on its neighbour's carry.
   function automatic logic [GPS:0] lookahead(input logic [GPS-1:0] g,
                                              input logic [GPS-1:0] p,
                                              input logic           cin);
      logic [GPS:0] c;
      logic         prod;
      c    = '0;
      c[0] = cin;
      for (int j = 1; j <= GPS; j++) begin
         prod = cin;
         for (int i = 0; i < j; i++) prod = prod & p[i];
         c[j] = prod;
         for (int i = 0; i < j; i++) begin
            prod = g[i];
            for (int m = i + 1; m < j; m++) prod = prod & p[m];
            c[j] = c[j] | prod;
         end
      end
      return c;
   endfunction

   // The whole pipeline moves together; a stalled output freezes every stage.
   logic w_adv;
   assign w_adv    = ~out_valid | out_ready;
   assign in_ready = w_adv;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int XW = WIDTH - k * SB;    // operand bits still unconsumed

      logic [XW-1:0]         w_x;
      logic [XW-1:0]         w_y;
      logic                  w_cin;
      logic                  w_vin;
      logic [GPS-1:0]        w_g;
      logic [GPS-1:0]        w_p;
      logic [GPS:0]          w_c;
      logic [SB-1:0]         w_sum;
      logic [(k+1)*SB-1:0]   w_sum_all;
      logic                  r_valid;
      logic                  r_cout;
      logic [(k+1)*SB-1:0]   r_sum;

      if (k == 0) begin : g_src
         assign w_x       = in_x;
         assign w_y       = in_y ^ {WIDTH{in_sub}};
         assign w_cin     = (in_sub == OP_SUB) ? 1'b1 : in_cin;
         assign w_vin     = in_valid;
         assign w_sum_all = w_sum;
      end else begin : g_src
         assign w_x       = g_stage[k-1].g_fwd.r_x;
         assign w_y       = g_stage[k-1].g_fwd.r_y;
         assign w_cin     = g_stage[k-1].r_cout;
         assign w_vin     = g_stage[k-1].r_valid;
         assign w_sum_all = {w_sum, g_stage[k-1].r_sum};
      end

      for (genvar j = 0; j < GPS; j++) begin : g_grp
         cla_group #(.BLOCK(BLOCK)) u_grp (
            .i_x   (w_x[j*BLOCK +: BLOCK]),
            .i_y   (w_y[j*BLOCK +: BLOCK]),
            .i_cin (w_c[j]),
            .o_sum (w_sum[j*BLOCK +: BLOCK]),
            .o_g   (w_g[j]),
            .o_p   (w_p[j])
         );
      end

      assign w_c = lookahead(w_g, w_p, w_cin);

      always_ff @(posedge clock or negedge reset_n) begin
         // NOTE: data registers are reset along with the valid bits so the
         // outputs read a defined 0 rather than X while nothing is valid.
         if (!reset_n) begin
            r_valid <= 1'b0;
            r_cout  <= 1'b0;
            r_sum   <= '0;
         end else if (w_adv) begin
            r_valid <= w_vin;
            r_cout  <= w_c[GPS];
            r_sum   <= w_sum_all;
         end
      end

      if (k < LAST) begin : g_fwd
         logic [XW-SB-1:0] r_x;
         logic [XW-SB-1:0] r_y;
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               r_x <= '0;
               r_y <= '0;
            end else if (w_adv) begin
               r_x <= w_x[XW-1:SB];
               r_y <= w_y[XW-1:SB];
            end
         end
      end else begin : g_last
         // Carry into the MSB recovered from the MSB sum bit and its operands.
         logic r_cmsb;
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n)   r_cmsb <= 1'b0;
            else if (w_adv) r_cmsb <= w_x[SB-1] ^ w_y[SB-1] ^ w_sum[SB-1];
         end
      end
   end

   assign out_valid = g_stage[LAST].r_valid;
   assign out_sum   = g_stage[LAST].r_sum;
   assign out_cout  = g_stage[LAST].r_cout;
   assign out_ovf   = g_stage[LAST].g_last.r_cmsb ^ g_stage[LAST].r_cout;
   assign out_zero  = g_stage[LAST].r_valid & ~|g_stage[LAST].r_sum;

endmodule

// File: tb/tb_pipe_cla_adder.sv
// -----------------------------------------------------------------------------
// tb_pipe_cla_adder
// Scoreboard bench. One driver issues transactions to a 32-bit/2-stage adder
// (A, with output backpressure); the same accepted transactions are mirrored
// into 32/4-stage (B), 16/1-stage (C) and 64/8-stage (D) instances that never
// stall. Expected responses are queued at acceptance and popped by per-DUT
// monitors on the falling edge.
// -----------------------------------------------------------------------------
module tb_pipe_cla_adder;

   typedef struct {
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
      int          stamp;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        tb_valid;
   logic [63:0] tb_x;
   logic [63:0] tb_y;
   logic        tb_cin;
   logic        tb_sub;
   logic        a_out_ready;
   logic        m_valid;
   int          rdy_mode;
   int          rcnt;
   int          cyc;
   int          total;
   int          bad;
   exp_t        cur_exp_a;
   exp_t        q_a[$];
   exp_t        q_b[$];
   exp_t        q_c[$];
   exp_t        q_d[$];

   logic a_in_ready, a_out_valid, a_cout, a_ovf, a_zero;
   logic b_in_ready, b_out_valid, b_cout, b_ovf, b_zero;
   logic c_in_ready, c_out_valid, c_cout, c_ovf, c_zero;
   logic d_in_ready, d_out_valid, d_cout, d_ovf, d_zero;
   logic [31:0] a_out_sum;
   logic [31:0] b_out_sum;
   logic [15:0] c_out_sum;
   logic [63:0] d_out_sum;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Mirrors take a transaction exactly when A accepts one.
   assign m_valid = tb_valid & a_in_ready;

   pipe_cla_adder #(.WIDTH(32), .BLOCK(8), .STAGES(2)) u_dut_a (
      .clock(clock), .reset_n(reset_n),
      .in_valid(tb_valid), .in_ready(a_in_ready),
      .in_x(tb_x[31:0]), .in_y(tb_y[31:0]), .in_cin(tb_cin), .in_sub(tb_sub),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_sum(a_out_sum), .out_cout(a_cout), .out_ovf(a_ovf), .out_zero(a_zero));

   pipe_cla_adder #(.WIDTH(32), .BLOCK(8), .STAGES(4)) u_dut_b (
      .clock(clock), .reset_n(reset_n),
      .in_valid(m_valid), .in_ready(b_in_ready),
      .in_x(tb_x[31:0]), .in_y(tb_y[31:0]), .in_cin(tb_cin), .in_sub(tb_sub),
      .out_valid(b_out_valid), .out_ready(1'b1),
      .out_sum(b_out_sum), .out_cout(b_cout), .out_ovf(b_ovf), .out_zero(b_zero));

   pipe_cla_adder #(.WIDTH(16), .BLOCK(8), .STAGES(1)) u_dut_c (
      .clock(clock), .reset_n(reset_n),
      .in_valid(m_valid), .in_ready(c_in_ready),
      .in_x(tb_x[15:0]), .in_y(tb_y[15:0]), .in_cin(tb_cin), .in_sub(tb_sub),
      .out_valid(c_out_valid), .out_ready(1'b1),
      .out_sum(c_out_sum), .out_cout(c_cout), .out_ovf(c_ovf), .out_zero(c_zero));

   pipe_cla_adder #(.WIDTH(64), .BLOCK(8), .STAGES(8)) u_dut_d (
      .clock(clock), .reset_n(reset_n),
      .in_valid(m_valid), .in_ready(d_in_ready),
      .in_x(tb_x), .in_y(tb_y), .in_cin(tb_cin), .in_sub(tb_sub),
      .out_valid(d_out_valid), .out_ready(1'b1),
      .out_sum(d_out_sum), .out_cout(d_cout), .out_ovf(d_ovf), .out_zero(d_zero));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [63:0] s, input logic c, input logic o, input logic z);
      exp_t e;
      e.sum = s; e.cout = c; e.ovf = o; e.zero = z; e.stamp = 0;
      return e;
   endfunction

   // Reference: plain wide addition, overflow from operand/result signs.
   function automatic exp_t model(input int w, input logic [63:0] x, input logic [63:0] y,
                                  input logic cin, input logic sub);
      exp_t        e;
      logic [63:0] mask, xm, ym, s;
      logic [64:0] full;
      mask   = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      xm     = x & mask;
      ym     = (sub ? ~y : y) & mask;
      full   = {1'b0, xm} + {1'b0, ym} + {64'd0, (sub ? 1'b1 : cin)};
      s      = full[63:0] & mask;
      e.sum  = s;
      e.cout = full[w];
      e.ovf  = (xm[w-1] == ym[w-1]) && (s[w-1] != xm[w-1]);
      e.zero = (s == 64'd0);
      e.stamp = 0;
      return e;
   endfunction

   task automatic compare(input string nm, input exp_t e, input logic [63:0] sum,
                          input logic cout, input logic ovf, input logic zero, input int lat);
      check({nm, "_sum"},  sum,  e.sum);
      check({nm, "_cout"}, 64'(cout), 64'(e.cout));
      check({nm, "_ovf"},  64'(ovf),  64'(e.ovf));
      check({nm, "_zero"}, 64'(zero), 64'(e.zero));
      if (lat > 0) check({nm, "_latency"}, 64'(cyc - e.stamp), 64'(lat));
   endtask

   // Acceptance: the transfer happens at the coming rising edge.
   always @(negedge clock) begin
      exp_t e;
      if (reset_n && tb_valid && a_in_ready) begin
         e = cur_exp_a; e.stamp = cyc;
         q_a.push_back(e);
         q_b.push_back(e);
         e = model(16, tb_x, tb_y, tb_cin, tb_sub); e.stamp = cyc;
         q_c.push_back(e);
         e = model(64, tb_x, tb_y, tb_cin, tb_sub); e.stamp = cyc;
         q_d.push_back(e);
      end
   end

   // Monitor A: handshake, stall hold and results.
   logic        a_stall_prev = 1'b0;
   logic [31:0] a_sum_prev;
   always @(negedge clock) begin
      exp_t e;
      if (reset_n) begin
         check("a_in_ready", 64'(a_in_ready), 64'(!(a_out_valid && !a_out_ready)));
         if (a_stall_prev) begin
            check("a_hold_valid", 64'(a_out_valid), 64'(1));
            check("a_hold_sum", 64'(a_out_sum), 64'(a_sum_prev));
         end
         if (a_out_valid && a_out_ready) begin
            check("a_queue_empty_on_output", 64'(q_a.size() == 0), 64'(0));
            if (q_a.size() != 0) begin
               e = q_a.pop_front();
               compare("a", e, 64'(a_out_sum), a_cout, a_ovf, a_zero, 0);
            end
         end
         a_stall_prev = a_out_valid && !a_out_ready;
         a_sum_prev   = a_out_sum;
      end else begin
         a_stall_prev = 1'b0;
      end
   end

   always @(negedge clock) begin
      exp_t e;
      if (reset_n && b_out_valid) begin
         check("b_queue_empty_on_output", 64'(q_b.size() == 0), 64'(0));
         if (q_b.size() != 0) begin
            e = q_b.pop_front();
            compare("b", e, 64'(b_out_sum), b_cout, b_ovf, b_zero, 4);
         end
      end
   end

   always @(negedge clock) begin
      exp_t e;
      if (reset_n && c_out_valid) begin
         check("c_queue_empty_on_output", 64'(q_c.size() == 0), 64'(0));
         if (q_c.size() != 0) begin
            e = q_c.pop_front();
            compare("c", e, 64'(c_out_sum), c_cout, c_ovf, c_zero, 1);
         end
      end
   end

   always @(negedge clock) begin
      exp_t e;
      if (reset_n && d_out_valid) begin
         check("d_queue_empty_on_output", 64'(q_d.size() == 0), 64'(0));
         if (q_d.size() != 0) begin
            e = q_d.pop_front();
            compare("d", e, d_out_sum, d_cout, d_ovf, d_zero, 8);
         end
      end
   end

   // out_ready for A: 0 = always, 1 = pattern 1,0,0,1, 2 = random (mostly 1).
   always @(posedge clock) begin
      #1;
      case (rdy_mode)
         1:       begin a_out_ready = (rcnt % 4 == 0) || (rcnt % 4 == 3); rcnt++; end
         2:       a_out_ready = ($urandom_range(0, 3) != 0);
         default: a_out_ready = 1'b1;
      endcase
   end

   task automatic issue(input logic [63:0] x, input logic [63:0] y, input logic cin,
                        input logic sub, input exp_t ea);
      int  n;
      logic acc;
      tb_x = x; tb_y = y; tb_cin = cin; tb_sub = sub; cur_exp_a = ea;
      tb_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clock);
         acc = a_in_ready;
         @(posedge clock);
         #1;
         if (acc) break;
         n++;
         if (n > 100) begin
            check("issue_accept_timeout", 64'(n), 64'(0));
            break;
         end
      end
      tb_valid = 1'b0;
   endtask

   task automatic issue_rand(input logic [63:0] x, input logic [63:0] y,
                             input logic cin, input logic sub);
      issue(x, y, cin, sub, model(32, x, y, cin, sub));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q_a.size() + q_b.size() + q_c.size() + q_d.size()) != 0 && n < 500) begin
         @(posedge clock);
         n++;
      end
      #1;
      check("drain_pending", 64'(q_a.size() + q_b.size() + q_c.size() + q_d.size()), 64'(0));
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] rx, ry;
      total = 0; bad = 0; cyc = 0; rcnt = 0; rdy_mode = 0;
      reset_n = 1'b0; tb_valid = 1'b0; tb_x = '0; tb_y = '0;
      tb_cin = 1'b0; tb_sub = 1'b0; a_out_ready = 1'b1;
      cur_exp_a = mk(64'd0, 1'b0, 1'b0, 1'b0);

      // Reset state.
      #2;
      check("rst_a_out_valid", 64'(a_out_valid), 64'(0));
      check("rst_a_in_ready",  64'(a_in_ready),  64'(1));
      check("rst_a_sum",       64'(a_out_sum),   64'(0));
      check("rst_a_cout",      64'(a_cout),      64'(0));
      check("rst_a_ovf",       64'(a_ovf),       64'(0));
      check("rst_a_zero",      64'(a_zero),      64'(0));
      check("rst_b_out_valid", 64'(b_out_valid), 64'(0));
      check("rst_d_zero",      64'(d_zero),      64'(0));
      #21 reset_n = 1'b1;
      @(posedge clock); #1;

      // Directed vectors, hand-computed 32-bit results.
      issue(64'hFFFFFFFF, 64'h00000001, 1'b0, 1'b0, mk(64'h00000000, 1'b1, 1'b0, 1'b1));
      issue(64'h80000000, 64'h00000001, 1'b0, 1'b1, mk(64'h7FFFFFFF, 1'b1, 1'b1, 1'b0));
      issue(64'h00000005, 64'h00000007, 1'b0, 1'b1, mk(64'hFFFFFFFE, 1'b0, 1'b0, 1'b0));
      issue(64'h0000FFFF, 64'h00000001, 1'b0, 1'b0, mk(64'h00010000, 1'b0, 1'b0, 1'b0));
      issue(64'h7FFFFFFF, 64'h00000000, 1'b1, 1'b0, mk(64'h80000000, 1'b0, 1'b1, 1'b0));
      issue(64'h12345678, 64'h11111111, 1'b1, 1'b0, mk(64'h2345678A, 1'b0, 1'b0, 1'b0));
      issue(64'h0000000A, 64'h0000000A, 1'b1, 1'b1, mk(64'h00000000, 1'b1, 1'b0, 1'b1));
      issue(64'hFFFFFFFF, 64'hFFFFFFFF, 1'b1, 1'b0, mk(64'hFFFFFFFF, 1'b1, 1'b0, 1'b0));
      issue(64'h00000000, 64'h00000001, 1'b0, 1'b1, mk(64'hFFFFFFFF, 1'b0, 1'b0, 1'b0));
      issue(64'h80000000, 64'h80000000, 1'b0, 1'b0, mk(64'h00000000, 1'b1, 1'b1, 1'b1));
      drain();

      // Backpressure: 10 back-to-back ops while out_ready runs 1,0,0,1.
      rcnt = 0; rdy_mode = 1;
      for (int i = 0; i < 10; i++) begin
         rx = {$urandom, $urandom};
         ry = {$urandom, $urandom};
         issue_rand(rx, ry, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      rdy_mode = 0;
      drain();

      // Reset mid-stream: three transactions in flight, then an async reset.
      issue_rand(64'h00000011, 64'h00000022, 1'b0, 1'b0);
      issue_rand(64'h00000033, 64'h00000044, 1'b1, 1'b0);
      issue_rand(64'h00000055, 64'h00000066, 1'b0, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      check("midrst_a_out_valid", 64'(a_out_valid), 64'(0));
      check("midrst_a_in_ready",  64'(a_in_ready),  64'(1));
      check("midrst_a_sum",       64'(a_out_sum),   64'(0));
      check("midrst_b_out_valid", 64'(b_out_valid), 64'(0));
      check("midrst_d_out_valid", 64'(d_out_valid), 64'(0));
      q_a.delete(); q_b.delete(); q_c.delete(); q_d.delete();
      #20 reset_n = 1'b1;
      // Any output now would be stale: the monitors flag it against empty queues.
      repeat (12) @(posedge clock);
      #1;

      // Random sweep with random backpressure on A.
      rdy_mode = 2;
      for (int i = 0; i < 1000; i++) begin
         rx = {$urandom, $urandom};
         ry = (i % 8 == 0) ? rx : {$urandom, $urandom};
         issue_rand(rx, ry, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      rdy_mode = 0;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
